rf_writeback: RTL and testbench

- Writeback stage directly upstream of the register file write port.
- Accepts one completed EXU result at a time via valid/ready.
- For loads, runs a word-aligned memory read handshake, then extracts and extends the load data.
- Drives the register file's wen/waddr/wdata for exactly one cycle, and exports a pending-destination bitmap for decode hazard stalls.

---
 rtl/rf_writeback.sv | 145 ++++++++++++++
 tb/tb_rf_writeback.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// Writeback stage feeding the register file write port: accepts one EXU result,
// performs the memory read for loads, and issues a single register file write.
module rf_writeback #(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_LEN   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_rd,
    input  logic [WORD_LEN-1:0]        in_result,
    input  logic                       in_is_load,
    input  logic [2:0]                 in_funct3,
    output logic                       mem_req,
    output logic [WORD_LEN-1:0]        mem_addr,
    input  logic                       mem_ack,
    input  logic                       mem_rvalid,
    input  logic [WORD_LEN-1:0]        mem_rdata,
    output logic                       wen,
    output logic [ADDR_WIDTH-1:0]      waddr,
    output logic [WORD_LEN-1:0]        wdata,
    output logic [2**ADDR_WIDTH-1:0]   busy_map,
    output logic                       load_err
);

    localparam int NREGS = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [WORD_LEN-1:0]   result_q;
    logic                  is_load_q;
    logic [2:0]            funct3_q;
    logic [WORD_LEN-1:0]   load_q;

    // Illegal funct3 encodings and misaligned halfword/word offsets.
    function automatic logic bad_load(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return off[0];
            3'b010:         return off != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic [WORD_LEN-1:0] extract(input logic [2:0] f3,
                                                    input logic [1:0] off,
                                                    input logic [WORD_LEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{(WORD_LEN-8){b[7]}}, b};
            3'b100:  return {{(WORD_LEN-8){1'b0}}, b};
            3'b001:  return {{(WORD_LEN-16){h[15]}}, h};
            3'b101:  return {{(WORD_LEN-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [NREGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] idx);
        logic [NREGS-1:0] o;
        o      = '0;
        o[idx] = 1'b1;
        return o;
    endfunction

    // These outputs are pure functions of registered state.
    assign waddr    = rd_q;
    assign mem_addr = {result_q[WORD_LEN-1:2], 2'b00};
    assign wdata    = is_load_q ? load_q : result_q;

    // NOTE: all state, including the registered outputs, uses non-blocking
    // assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rd_q      <= '0;
            result_q  <= '0;
            is_load_q <= 1'b0;
            funct3_q  <= '0;
            load_q    <= '0;
            in_ready  <= 1'b0;
            mem_req   <= 1'b0;
            wen       <= 1'b0;
            load_err  <= 1'b0;
            busy_map  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        rd_q      <= in_rd;
                        result_q  <= in_result;
                        is_load_q <= in_is_load;
                        funct3_q  <= in_funct3;
                        in_ready  <= 1'b0;
                        busy_map  <= (in_rd != '0) ? onehot(in_rd) : '0;
                        if (!in_is_load) begin
                            wen   <= (in_rd != '0);
                            state <= S_WB;
                        end else if (bad_load(in_funct3, in_result[1:0])) begin
                            load_err <= 1'b1;
                            state    <= S_WB;
                        end else begin
                            mem_req <= 1'b1;
                            state   <= S_REQ;
                        end
                    end
                end
                // rvalid is deliberately ignored here; data arrives only after ack.
                S_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        load_q <= extract(funct3_q, result_q[1:0], mem_rdata);
                        wen    <= (rd_q != '0);
                        state  <= S_WB;
                    end
                end
                S_WB: begin
                    wen      <= 1'b0;
                    load_err <= 1'b0;
                    busy_map <= '0;
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed scenarios plus randomized
// transactions checked against an arithmetic model of the load rules.
module tb_rf_writeback;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] busy_map;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    rf_writeback #(.ADDR_WIDTH(5), .WORD_LEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_result  (in_result),
        .in_is_load (in_is_load),
        .in_funct3  (in_funct3),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy_map   (busy_map),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: load legality and extraction from plain arithmetic.
    function automatic bit model_err(input bit is_load, input bit [2:0] f3, input int unsigned addr);
        if (!is_load) return 0;
        if (f3 == 3 || f3 >= 6) return 1;
        if (f3 == 1 || f3 == 5) return (addr % 2) != 0;
        if (f3 == 2) return (addr % 4) != 0;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input bit [2:0] f3, input int unsigned addr,
                                               input logic [31:0] word);
        int unsigned off;
        byte         sb;
        shortint     sh;
        off = addr % 4;
        case (f3)
            3'd0: begin sb = byte'(word >> (8 * off)); return int'(sb); end
            3'd4: return (word >> (8 * off)) & 32'hFF;
            3'd1: begin sh = shortint'(word >> (16 * (off / 2))); return int'(sh); end
            3'd5: return (word >> (16 * (off / 2))) & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one full transaction and checks every stage against the model.
    task automatic run_txn(input logic [4:0] rd, input logic [31:0] res, input bit ld,
                           input bit [2:0] f3, input logic [31:0] rdata,
                           input int ack_dly, input int rv_dly, input string tag);
        bit          err;
        bit          exp_wen;
        logic [31:0] exp_data;
        logic [31:0] exp_busy;
        logic [31:0] exp_addr;
        err      = model_err(ld, f3, res);
        exp_wen  = (rd != 0) && !err;
        exp_data = ld ? model_load(f3, res, rdata) : res;
        exp_busy = (rd != 0) ? (32'h1 << rd) : 32'h0;
        exp_addr = res & 32'hFFFF_FFFC;

        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s idle_ready got %b want 1", tag, in_ready);
        end
        in_valid = 1'b1; in_rd = rd; in_result = res; in_is_load = ld; in_funct3 = f3;
        tick();
        // Garbage on the input bus while busy must be ignored.
        in_valid = 1'($urandom); in_rd = 5'($urandom); in_result = $urandom;
        in_is_load = 1'($urandom); in_funct3 = 3'($urandom);

        if (ld && !err) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr || busy_map !== exp_busy || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s req_entry got req=%b addr=%h busy=%h rdy=%b want req=1 addr=%h busy=%h rdy=0",
                         tag, mem_req, mem_addr, busy_map, in_ready, exp_addr, exp_busy);
            end
            for (int i = 0; i < ack_dly; i++) begin
                tick();
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== exp_addr || in_ready !== 1'b0 || wen !== 1'b0) begin
                    errors++;
                    $display("FAIL %s req_hold got req=%b addr=%h rdy=%b wen=%b want req=1 addr=%h rdy=0 wen=0",
                             tag, mem_req, mem_addr, in_ready, wen, exp_addr);
                end
            end
            // rvalid alongside ack must not be sampled.
            mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = ~rdata;
            tick();
            mem_ack = 1'b0; mem_rvalid = 1'b0;
            checks++;
            if (mem_req !== 1'b0 || wen !== 1'b0 || busy_map !== exp_busy) begin
                errors++;
                $display("FAIL %s wait_entry got req=%b wen=%b busy=%h want req=0 wen=0 busy=%h",
                         tag, mem_req, wen, busy_map, exp_busy);
            end
            for (int i = 0; i < rv_dly; i++) begin
                tick();
                checks++;
                if (wen !== 1'b0 || in_ready !== 1'b0 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s wait_hold got wen=%b rdy=%b req=%b want 0 0 0", tag, wen, in_ready, mem_req);
                end
            end
            mem_rvalid = 1'b1; mem_rdata = rdata;
            tick();
            mem_rvalid = 1'b0; mem_rdata = $urandom;
        end else if (ld) begin
            checks++;
            if (mem_req !== 1'b0) begin
                errors++; $display("FAIL %s bad_load_no_req got %b want 0", tag, mem_req);
            end
        end

        in_valid = 1'b0;
        checks++;
        if (wen !== exp_wen || waddr !== rd || load_err !== err || busy_map !== exp_busy || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s wb got wen=%b waddr=%0d err=%b busy=%h rdy=%b want wen=%b waddr=%0d err=%b busy=%h rdy=0",
                     tag, wen, waddr, load_err, busy_map, in_ready, exp_wen, rd, err, exp_busy);
        end
        if (!err) begin
            checks++;
            if (wdata !== exp_data) begin
                errors++; $display("FAIL %s wb_data got %h want %h", tag, wdata, exp_data);
            end
        end
        tick();
        checks++;
        if (wen !== 1'b0 || load_err !== 1'b0 || busy_map !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post_wb got wen=%b err=%b busy=%h rdy=%b want 0 0 0 1",
                     tag, wen, load_err, busy_map, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (in_ready !== 1'b0 || mem_req !== 1'b0 || wen !== 1'b0 || load_err !== 1'b0 || busy_map !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold got rdy=%b req=%b wen=%b err=%b busy=%h want all 0",
                     in_ready, mem_req, wen, load_err, busy_map);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || wen !== 1'b0) begin
            errors++; $display("FAIL reset_release got rdy=%b wen=%b want 1 0", in_ready, wen);
        end
    endtask

    task automatic test_alu();
        run_txn(5'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'h0, 0, 0, "alu");
    endtask

    task automatic test_x0();
        run_txn(5'd0, 32'h0000_1234, 1'b0, 3'd0, 32'h0, 0, 0, "x0_alu");
        run_txn(5'd0, 32'h0000_2000, 1'b1, 3'd2, 32'hCAFEF00D, 1, 0, "x0_load");
    endtask

    task automatic test_lb();
        run_txn(5'd7, 32'h8000_0003, 1'b1, 3'd0, 32'h80FF_0011, 0, 0, "lb_sign");
        run_txn(5'd9, 32'h0000_0011, 1'b1, 3'd4, 32'h1122_33F4, 1, 1, "lbu");
    endtask

    task automatic test_lhu_misaligned();
        run_txn(5'd12, 32'h0000_2002, 1'b1, 3'd5, 32'hBEEF_1234, 0, 0, "lhu");
        run_txn(5'd13, 32'h0000_1001, 1'b1, 3'd2, 32'h0, 0, 0, "lw_misaligned");
        run_txn(5'd14, 32'h0000_1003, 1'b1, 3'd1, 32'h0, 0, 0, "lh_misaligned");
        run_txn(5'd15, 32'h0000_1000, 1'b1, 3'd6, 32'h0, 0, 0, "illegal_f3");
        run_txn(5'd16, 32'h0000_3002, 1'b1, 3'd1, 32'h8001_7FFF, 0, 0, "lh_sign");
    endtask

    task automatic test_slow_mem();
        run_txn(5'd21, 32'h0000_4000, 1'b1, 3'd2, 32'h1357_9BDF, 4, 2, "slow_mem");
    endtask

    task automatic test_reset_mid_req();
        in_valid = 1'b1; in_rd = 5'd5; in_result = 32'h0000_0100; in_is_load = 1'b1; in_funct3 = 3'd2;
        tick();
        in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || busy_map !== 32'h20) begin
            errors++; $display("FAIL midreq_entry got req=%b busy=%h want 1 00000020", mem_req, busy_map);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || wen !== 1'b0 || busy_map !== 32'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreq_reset got req=%b wen=%b busy=%h rdy=%b want 0 0 0 0",
                     mem_req, wen, busy_map, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreq_release_ready got %b want 1", in_ready);
        end
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (wen !== 1'b0 || busy_map !== 32'h0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL midreq_stale_rvalid got wen=%b busy=%h req=%b want 0 0 0", wen, busy_map, mem_req);
            end
        end
        mem_ack = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_txn(5'($urandom), $urandom, 1'($urandom), 3'($urandom), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_rd = '0; in_result = '0; in_is_load = 1'b0;
        in_funct3 = '0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_x0();
        test_lb();
        test_lhu_misaligned();
        test_slow_mem();
        test_reset_mid_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
